canvas_clear_scheduler: RTL
===========================

CANVAS_CLEAR_SCHEDULER -- requirements
Module: canvas_clear_scheduler

Interface
REQ-001 Parameter WIDTH, default 640, canvas width in pixels.
REQ-002 Parameter HEIGHT, default 480, canvas height in pixels.
REQ-003 Parameter COLOR_WIDTH, default 3, color word width.
REQ-004 Parameter CLEAR_COLOR, default 0, color written by the sweep (transparent/none).
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 clear_req  input  1  request to clear layer clear_layer; sampled only in IDLE.
REQ-008 clear_layer  input  3  target layer, valid values 1..4.
REQ-009 clear_abort  input  1  abandon the sweep in progress.
REQ-010 tool_valid  input  1  freehand tool has a pixel write this cycle.
REQ-011 tool_x / tool_y  input  $clog2(WIDTH) / $clog2(HEIGHT)  tool pixel coordinate.
REQ-012 tool_color  input  COLOR_WIDTH  tool pixel color.
REQ-013 tool_layer  input  3  layer the tool writes to.
REQ-014 wr_en  output  1  registered canvas write strobe.
REQ-015 wr_x / wr_y  output  $clog2(WIDTH) / $clog2(HEIGHT)  registered write coordinate.
REQ-016 wr_color  output  COLOR_WIDTH  registered write color.
REQ-017 wr_layer  output  3  registered layer select for the write.
REQ-018 busy  output  1  high in CLEAR and DONE.
REQ-019 clear_done  output  1  one-cycle pulse on sweep completion.

Function
REQ-020 States: IDLE, CLEAR, DONE; the state register SHALL hold only these encodings.
REQ-021 IDLE: on clear_req=1 with clear_layer in 1..4, latch layer, sweep x=0, y=0, go to CLEAR; clear_layer 0 or 5..7 ignored, stay IDLE.
REQ-022 Every write output SHALL be registered: inputs sampled at edge k appear on wr_* after edge k (1-cycle latency).
REQ-023 Arbitration: tool_valid=1 SHALL always win; wr_* = tool_x, tool_y, tool_color, tool_layer, wr_en=1, in any state.
REQ-024 CLEAR with tool_valid=0: emit wr_en=1, wr_x=x, wr_y=y, wr_color=CLEAR_COLOR, wr_layer=latched layer; then advance the counter.
REQ-025 CLEAR with tool_valid=1: sweep counter SHALL hold (no pixel skipped or repeated).
REQ-026 Counter advance: x+1 if x<WIDTH-1; else x=0 and y+1; no wrap beyond HEIGHT-1.
REQ-027 The edge emitting pixel (WIDTH-1, HEIGHT-1) SHALL move state to DONE.
REQ-028 DONE: clear_done=1 for exactly that cycle, busy=1; next edge -> IDLE unconditionally.
REQ-029 clear_req during CLEAR or DONE SHALL be ignored (not queued).
REQ-030 clear_abort=1 in CLEAR: no sweep write that edge, go to IDLE, clear_done stays 0; a tool write that edge still issues.
REQ-031 clear_abort and clear_req both high in IDLE: clear_req wins, sweep starts.
REQ-032 Sweep write count per completed clear SHALL equal WIDTH*HEIGHT exactly; cycles from request edge to clear_done = WIDTH*HEIGHT + tool-win cycles + 1.
REQ-033 With no tool write and not sweeping, wr_en=0; wr_x/wr_y/wr_color/wr_layer hold last value.

Reset
REQ-034 reset_n=0 SHALL immediately (no clock) force state=IDLE, x=y=0, latched layer=0, wr_en=0, wr_x=wr_y=0, wr_color=0, wr_layer=0, busy=0, clear_done=0.
REQ-035 Reset mid-sweep SHALL discard the sweep; no clear_done after release.
REQ-036 First edge after reset_n rises SHALL behave as IDLE.

Verification (WIDTH=4, HEIGHT=2, CLEAR_COLOR=0)
REQ-037 clear_req=1, clear_layer=2 for one cycle, tool_valid=0 -> 8 writes (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1) on layer 2, color 0, consecutive cycles; clear_done pulses once the cycle after (3,1); busy falls after.
REQ-038 Same sweep with tool_valid=1 (5,?,color 7 -> use (1,1),color 7,layer 1) during sweep pixel (2,0) -> tool write on layer 1 that cycle, then (2,0) next cycle; total sweep writes still 8, clear_done delayed 1 cycle.
REQ-039 clear_req=1 with clear_layer=0 and =5 -> busy stays 0, no wr_en.
REQ-040 clear_abort at pixel (1,0) -> no further sweep writes, busy=0 next cycle, clear_done never asserted; new clear_req=1 layer 3 restarts at (0,0).
REQ-041 reset_n pulsed low asynchronously mid-sweep between edges -> all outputs 0 immediately; after release no writes until new clear_req.
REQ-042 clear_req held high through entire sweep -> exactly one sweep, then a second sweep starts on the first edge in IDLE.

Source files
------------

// File: rtl/canvas_clear_scheduler_if.sv
`default_nettype none
// ============================================================================
// canvas_clear_scheduler_if : clear request, freehand tool and canvas write bundle
// Revision: 1.0
// ============================================================================
interface canvas_clear_scheduler_if #(
   parameter int WIDTH       = 640,
   parameter int HEIGHT      = 480,
   parameter int COLOR_WIDTH = 3
);
   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);

   logic                   clear_req;
   logic [2:0]             clear_layer;
   logic                   clear_abort;
   logic                   tool_valid;
   logic [XW-1:0]          tool_x;
   logic [YW-1:0]          tool_y;
   logic [COLOR_WIDTH-1:0] tool_color;
   logic [2:0]             tool_layer;
   logic                   wr_en;
   logic [XW-1:0]          wr_x;
   logic [YW-1:0]          wr_y;
   logic [COLOR_WIDTH-1:0] wr_color;
   logic [2:0]             wr_layer;
   logic                   busy;
   logic                   clear_done;

   modport master (
      output clear_req, clear_layer, clear_abort,
      output tool_valid, tool_x, tool_y, tool_color, tool_layer,
      input  wr_en, wr_x, wr_y, wr_color, wr_layer, busy, clear_done
   );

   modport slave (
      input  clear_req, clear_layer, clear_abort,
      input  tool_valid, tool_x, tool_y, tool_color, tool_layer,
      output wr_en, wr_x, wr_y, wr_color, wr_layer, busy, clear_done
   );
endinterface
`default_nettype wire

// File: rtl/canvas_clear_scheduler.sv
`default_nettype none
// ============================================================================
// canvas_clear_scheduler : sweeps one layer to CLEAR_COLOR, yielding to tool writes
// Revision: 1.0
// ============================================================================
module canvas_clear_scheduler #(
   parameter int                     WIDTH       = 640,
   parameter int                     HEIGHT      = 480,
   parameter int                     COLOR_WIDTH = 3,
   parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = '0
) (
   input wire logic                 clk,
   input wire logic                 reset_n,
   canvas_clear_scheduler_if.slave  bus
);
   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);
   localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CLEAR = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]             state;
   logic [XW-1:0]          sweep_x;
   logic [YW-1:0]          sweep_y;
   logic [2:0]             sweep_layer;
   logic                   wr_en_q;
   logic [XW-1:0]          wr_x_q;
   logic [YW-1:0]          wr_y_q;
   logic [COLOR_WIDTH-1:0] wr_color_q;
   logic [2:0]             wr_layer_q;

   logic layer_ok;
   logic sweep_last;

   assign layer_ok   = (bus.clear_layer >= 3'd1) && (bus.clear_layer <= 3'd4);
   assign sweep_last = (sweep_x == X_LAST) && (sweep_y == Y_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         sweep_x     <= '0;
         sweep_y     <= '0;
         sweep_layer <= '0;
         wr_en_q     <= 1'b0;
         wr_x_q      <= '0;
         wr_y_q      <= '0;
         wr_color_q  <= '0;
         wr_layer_q  <= '0;
      end else begin
         wr_en_q <= 1'b0;

         // The tool owns the write port whenever it asks; the sweep only fills idle slots.
         if (bus.tool_valid) begin
            wr_en_q    <= 1'b1;
            wr_x_q     <= bus.tool_x;
            wr_y_q     <= bus.tool_y;
            wr_color_q <= bus.tool_color;
            wr_layer_q <= bus.tool_layer;
         end

         case (state)
            IDLE: begin
               if (bus.clear_req && layer_ok) begin
                  sweep_layer <= bus.clear_layer;
                  sweep_x     <= '0;
                  sweep_y     <= '0;
                  state       <= CLEAR;
               end
            end
            CLEAR: begin
               if (bus.clear_abort) begin
                  state <= IDLE;
               end else if (!bus.tool_valid) begin
                  wr_en_q    <= 1'b1;
                  wr_x_q     <= sweep_x;
                  wr_y_q     <= sweep_y;
                  wr_color_q <= CLEAR_COLOR;
                  wr_layer_q <= sweep_layer;
                  if (sweep_last) begin
                     state <= DONE;
                  end else if (sweep_x == X_LAST) begin
                     sweep_x <= '0;
                     sweep_y <= sweep_y + 1'b1;
                  end else begin
                     sweep_x <= sweep_x + 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.wr_en      = wr_en_q;
   assign bus.wr_x       = wr_x_q;
   assign bus.wr_y       = wr_y_q;
   assign bus.wr_color   = wr_color_q;
   assign bus.wr_layer   = wr_layer_q;
   assign bus.busy       = (state == CLEAR) || (state == DONE);
   assign bus.clear_done = (state == DONE);

endmodule
`default_nettype wire
